// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-requester write arbiter in front of a 16-entry FIFO.
// Grants are round-robin on ties (last-served pointer) and a grant lasts for a
// burst of up to BURST_LEN words. The owner's ack and the FIFO write enable are
// combinational so a word can be accepted in the same cycle it is presented.
// Optional feature: define FIFO_ARB_STALL_CNT_EN to add the 16-bit saturating
// stall_cnt output, which counts cycles where the owner was blocked by f_full.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_data,
    output logic              m0_grant,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_data,
    output logic              m1_grant,
    output logic              m1_ack,
    input  logic              f_full,
    output logic              f_wr_en,
    output logic [DATA_W-1:0] f_din,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     state;
    state_t     nxt_state;
    logic       last_served;
    logic       nxt_last;
    logic [3:0] burst_cnt;
    logic [3:0] nxt_cnt;

    logic       own_req;
    logic       other_req;
    logic       own_ack;
    logic       burst_done;

    // Select the owner's and the waiting requester's request lines for the current state.
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        case (state)
            GRANT0: begin
                own_req   = m0_req;
                other_req = m1_req;
            end
            GRANT1: begin
                own_req   = m1_req;
                other_req = m0_req;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

    // A full FIFO freezes the burst entirely; otherwise the burst ends on a
    // missing request or on the ack that completes BURST_LEN words.
    assign own_ack    = own_req & ~f_full & ~reset;
    assign burst_done = ~f_full & (~own_req | (burst_cnt == LAST_BEAT));

    assign m0_ack  = (state == GRANT0) & own_ack;
    assign m1_ack  = (state == GRANT1) & own_ack;
    assign f_wr_en = own_ack;

    // Route the owner's data to the FIFO; drive zero when nobody owns the port.
    always_comb begin
        f_din = '0;
        case (state)
            GRANT0:  f_din = m0_data;
            GRANT1:  f_din = m1_data;
            default: f_din = '0;
        endcase
    end

    // Next-state decision: tie-break from IDLE, burst counting and handoff in GRANT states.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = burst_cnt;
        nxt_last  = last_served;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || last_served)) begin
                    nxt_state = GRANT0;
                    nxt_cnt   = 4'd0;
                    nxt_last  = 1'b0;
                end else if (m1_req) begin
                    nxt_state = GRANT1;
                    nxt_cnt   = 4'd0;
                    nxt_last  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (burst_done) begin
                    nxt_cnt = 4'd0;
                    if (other_req) begin
                        nxt_state = (state == GRANT0) ? GRANT1 : GRANT0;
                        nxt_last  = (state == GRANT0);
                    end else if (!own_req) begin
                        nxt_state = IDLE;
                    end
                end else if (own_ack) begin
                    nxt_cnt = burst_cnt + 4'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = 4'd0;
            end
        endcase
    end

    // Arbiter state register with registered grant and busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= 4'd0;
            last_served <= 1'b1;
            m0_grant    <= 1'b0;
            m1_grant    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            burst_cnt   <= nxt_cnt;
            last_served <= nxt_last;
            m0_grant    <= (nxt_state == GRANT0);
            m1_grant    <= (nxt_state == GRANT1);
            busy        <= (nxt_state == GRANT0) || (nxt_state == GRANT1);
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // Count cycles where the owner wanted to write but the FIFO was full; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (own_req && f_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;

    logic              clk;
    logic              reset;
    logic              m0_req;
    logic [DATA_W-1:0] m0_data;
    logic              m0_grant;
    logic              m0_ack;
    logic              m1_req;
    logic [DATA_W-1:0] m1_data;
    logic              m1_grant;
    logic              m1_ack;
    logic              f_full;
    logic              f_wr_en;
    logic [DATA_W-1:0] f_din;
    logic              busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, words written in this burst, who was served last.
    int mdl_owner;
    int mdl_words;
    int mdl_last;

    fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_data  (m0_data),
        .m0_grant (m0_grant),
        .m0_ack   (m0_ack),
        .m1_req   (m1_req),
        .m1_data  (m1_data),
        .m1_grant (m1_grant),
        .m1_ack   (m1_ack),
        .f_full   (f_full),
        .f_wr_en  (f_wr_en),
        .f_din    (f_din),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs on the falling edge, then settle before sampling.
    task automatic drive(input logic r0, input logic [DATA_W-1:0] d0,
                         input logic r1, input logic [DATA_W-1:0] d1,
                         input logic full, input logic rst);
        @(negedge clk);
        m0_req  = r0;
        m0_data = d0;
        m1_req  = r1;
        m1_data = d1;
        f_full  = full;
        reset   = rst;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // Advance the reference model across one rising edge given this cycle's inputs.
    task automatic model_edge(input bit r0, input bit r1, input bit full, input bit rst);
        bit reqs[2];
        reqs[0] = r0;
        reqs[1] = r1;
        if (rst) begin
            mdl_owner = -1;
            mdl_words = 0;
            mdl_last  = 1;
        end else if (mdl_owner < 0) begin
            if (r0 && r1)  mdl_owner = 1 - mdl_last;
            else if (r0)   mdl_owner = 0;
            else if (r1)   mdl_owner = 1;
            if (mdl_owner >= 0) begin
                mdl_last  = mdl_owner;
                mdl_words = 0;
            end
        end else if (!full) begin
            bit finished;
            finished = 1'b0;
            if (!reqs[mdl_owner]) begin
                finished = 1'b1;
            end else begin
                mdl_words++;
                if (mdl_words == BURST_LEN) finished = 1'b1;
            end
            if (finished) begin
                mdl_words = 0;
                if (reqs[1 - mdl_owner]) begin
                    mdl_owner = 1 - mdl_owner;
                    mdl_last  = mdl_owner;
                end else if (!reqs[mdl_owner]) begin
                    mdl_owner = -1;
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b0, 1'b1);
        checks++;
        if ({m1_ack, m0_ack, f_wr_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_comb_acks: got %b expected 000", {m1_ack, m0_ack, f_wr_en});
        end
        drive(1'b0, 32'h1111_1111, 1'b0, 32'h2222_2222, 1'b0, 1'b1);
        checks++;
        if ({m1_grant, m0_grant, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected 000", {m1_grant, m0_grant, busy});
        end
        checks++;
        if (f_din !== '0) begin
            errors++;
            $display("[TB] FAIL reset_din: got %h expected 0", f_din);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    // Both requesters always busy: 4 words each, alternating, no idle gap.
    task automatic test_tie_alternation();
        int w0 = 0;
        int w1 = 0;
        int who;
        logic [1:0]        exp_ack;
        logic [DATA_W-1:0] exp_din;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            drive(1'b1, 32'hA000_0000 + DATA_W'(w0), 1'b1, 32'hB000_0000 + DATA_W'(w1), 1'b0, 1'b0);
            who = (c == 0) ? -1 : ((c - 1) / BURST_LEN) % 2;
            exp_ack = (who == 0) ? 2'b01 : (who == 1) ? 2'b10 : 2'b00;
            checks++;
            if ({m1_ack, m0_ack} !== exp_ack) begin
                errors++;
                $display("[TB] FAIL tie_ack c=%0d: got %b expected %b", c, {m1_ack, m0_ack}, exp_ack);
            end
            if (who >= 0) begin
                exp_din = (who == 0) ? 32'hA000_0000 + DATA_W'(w0) : 32'hB000_0000 + DATA_W'(w1);
                checks++;
                if (f_din !== exp_din) begin
                    errors++;
                    $display("[TB] FAIL tie_din c=%0d: got %h expected %h", c, f_din, exp_din);
                end
            end
            if (who == 0) w0++;
            if (who == 1) w1++;
        end
    endtask

    // m1 alone with 6 words: burst of 4, regrant, 2 more, then IDLE after request drops.
    task automatic test_single_burst();
        int w1 = 0;
        logic [1:0] exp_ack;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, '0, (w1 < 6), 32'hC000_0000 + DATA_W'(w1), 1'b0, 1'b0);
            exp_ack = (c >= 1 && c <= 6) ? 2'b10 : 2'b00;
            checks++;
            if ({m1_ack, m0_ack} !== exp_ack) begin
                errors++;
                $display("[TB] FAIL single_ack c=%0d: got %b expected %b", c, {m1_ack, m0_ack}, exp_ack);
            end
            if (c >= 1 && c <= 7) begin
                checks++;
                if ({m1_grant, m0_grant} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL single_grant c=%0d: got %b expected 10", c, {m1_grant, m0_grant});
                end
            end
            if (c == 8) begin
                checks++;
                if ({m1_grant, m0_grant, busy} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL single_idle: got %b expected 000", {m1_grant, m0_grant, busy});
                end
            end
            if (exp_ack[1]) w1++;
        end
    endtask

    // FIFO full for 3 cycles after the 2nd m0 word; 16 writes still complete in order.
    task automatic test_full_stall();
        int w0 = 0;
        int w1 = 0;
        int writes = 0;
        int k;
        int who;
        logic full;
        logic [1:0] exp_ack;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            full = (c >= 3 && c <= 5);
            drive(1'b1, 32'hD000_0000 + DATA_W'(w0), 1'b1, 32'hE000_0000 + DATA_W'(w1), full, 1'b0);
            if (c == 0 || full) k = -1;
            else if (c < 3)     k = c - 1;
            else                k = c - 4;
            who = (k < 0) ? -1 : (k / BURST_LEN) % 2;
            exp_ack = (who == 0) ? 2'b01 : (who == 1) ? 2'b10 : 2'b00;
            checks++;
            if ({m1_ack, m0_ack, f_wr_en} !== {exp_ack, exp_ack != 2'b00}) begin
                errors++;
                $display("[TB] FAIL stall_ack c=%0d: got %b expected %b", c,
                         {m1_ack, m0_ack, f_wr_en}, {exp_ack, exp_ack != 2'b00});
            end
            if (f_wr_en === 1'b1) writes++;
            if (who == 0) w0++;
            if (who == 1) w1++;
        end
        checks++;
        if (writes != 16) begin
            errors++;
            $display("[TB] FAIL stall_total_writes: got %0d expected 16", writes);
        end
    endtask

    // Reset in the middle of an m0 burst aborts it; m0 wins the following tie.
    task automatic test_reset_mid_burst();
        logic [1:0] exp_ack;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h5000_0000, 1'b1, 32'h6000_0000, 1'b0, (c == 3));
            exp_ack = (c == 1 || c == 2 || c == 5) ? 2'b01 : 2'b00;
            checks++;
            if ({m1_ack, m0_ack, f_wr_en} !== {exp_ack, exp_ack != 2'b00}) begin
                errors++;
                $display("[TB] FAIL rstmid_ack c=%0d: got %b expected %b", c,
                         {m1_ack, m0_ack, f_wr_en}, {exp_ack, exp_ack != 2'b00});
            end
            if (c == 4) begin
                checks++;
                if ({m1_grant, m0_grant, busy} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL rstmid_idle: got %b expected 000", {m1_grant, m0_grant, busy});
                end
            end
            if (c == 5) begin
                checks++;
                if ({m1_grant, m0_grant} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL rstmid_tie: got %b expected 01", {m1_grant, m0_grant});
                end
            end
        end
    endtask

    // m0 drops after one word while m1 waits: m1 takes over on the next edge.
    task automatic test_early_drop();
        do_reset();
        drive(1'b1, 32'h7000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h7000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        checks++;
        if ({m1_ack, m0_ack} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL drop_first_ack: got %b expected 01", {m1_ack, m0_ack});
        end
        drive(1'b0, 32'h7000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        checks++;
        if ({m1_grant, m0_grant, m1_ack, m0_ack} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL drop_wait: got %b expected 0100", {m1_grant, m0_grant, m1_ack, m0_ack});
        end
        drive(1'b0, 32'h7000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        checks++;
        if ({m1_grant, m0_grant, m1_ack, m0_ack} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL drop_handoff: got %b expected 1010", {m1_grant, m0_grant, m1_ack, m0_ack});
        end
    endtask

`ifdef FIFO_ARB_STALL_CNT_EN
    // Five full cycles while m0 owns the port; the full cycle in IDLE must not count.
    task automatic test_stall_cnt();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h9000_0000, 1'b0, '0, 1'b1, 1'b0);
        end
        drive(1'b1, 32'h9000_0000, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL stall_cnt: got %0d expected 5", stall_cnt);
        end
        checks++;
        if (m0_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_cnt_resume_ack: got %b expected 1", m0_ack);
        end
    endtask
`endif

    // Random requesters, full flag and occasional reset, compared with the model every cycle.
    task automatic test_random();
        bit p0 = 0;
        bit p1 = 0;
        bit full;
        bit rst;
        bit e0;
        bit e1;
        logic [DATA_W-1:0] cur0 = '0;
        logic [DATA_W-1:0] cur1 = '0;
        logic [DATA_W-1:0] exp_din;
        do_reset();
        model_edge(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0   = 1'b1;
                cur0 = DATA_W'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1   = 1'b1;
                cur1 = DATA_W'($urandom);
            end
            full = ($urandom_range(0, 4) == 0);
            rst  = ($urandom_range(0, 79) == 0);
            drive(p0, cur0, p1, cur1, full, rst);
            e0 = (mdl_owner == 0) && p0 && !full && !rst;
            e1 = (mdl_owner == 1) && p1 && !full && !rst;
            exp_din = (mdl_owner == 0) ? cur0 : (mdl_owner == 1) ? cur1 : '0;
            checks++;
            if ({m1_ack, m0_ack, f_wr_en} !== {e1, e0, e0 | e1}) begin
                errors++;
                $display("[TB] FAIL rand_ack c=%0d: got %b expected %b", c,
                         {m1_ack, m0_ack, f_wr_en}, {e1, e0, e0 | e1});
            end
            checks++;
            if (f_din !== exp_din) begin
                errors++;
                $display("[TB] FAIL rand_din c=%0d: got %h expected %h", c, f_din, exp_din);
            end
            checks++;
            if ({m1_grant, m0_grant, busy} !== {mdl_owner == 1, mdl_owner == 0, mdl_owner >= 0}) begin
                errors++;
                $display("[TB] FAIL rand_grant c=%0d: got %b expected %b", c, {m1_grant, m0_grant, busy},
                         {mdl_owner == 1, mdl_owner == 0, mdl_owner >= 0});
            end
            model_edge(p0, p1, full, rst);
            if (e0) p0 = 1'b0;
            if (e1) p1 = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        m0_data = '0;
        m1_data = '0;
        f_full  = 1'b0;
        mdl_owner = -1;
        mdl_words = 0;
        mdl_last  = 1;
        $display("[TB] starting fifo_wr_arbiter bench");
        test_reset();
        test_tie_alternation();
        test_single_burst();
        test_full_stall();
        test_reset_mid_burst();
        test_early_drop();
`ifdef FIFO_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
